// File: rtl/mpy_pkg.sv
// mpy_pkg
// Shared definitions for the sequential multiplier and the ALU decoder:
// the multiply function-select codes, the multiplier FSM state encoding,
// and a small helper that recognises a multiply request.

package mpy_pkg;

    // Function-select codes, shared with the ALU decoder
    localparam logic [4:0] FS_MULT  = 5'h02;
    localparam logic [4:0] FS_MULTU = 5'h03;

    // Multiplier FSM states
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    // True when the function-select code asks for a multiply
    function automatic logic is_mul_fs(input logic [4:0] fs);
        return (fs == FS_MULT) || (fs == FS_MULTU);
    endfunction

endpackage

// File: rtl/mpy_abs.sv
// mpy_abs
// Conditional two's-complement of a W-bit value. Used to form operand
// magnitudes at accept time and to negate the final product.
// Ports:
//   a    in  W  value to transform
//   neg  in  1  when high, the output is -a (modulo 2^W), else a
//   mag  out W  result, read as unsigned

module mpy_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] mag
);

    // The most negative input maps onto itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign mag = neg ? -a : a;

endmodule

// File: rtl/mpy_seq.sv
// mpy_seq
// Sequential shift-add multiplier, signed (MULT) or unsigned (MULTU),
// producing a 2W-bit product W+1 cycles after an accepted start.
// Ports:
//   clk    in  1  clock, rising edge
//   reset  in  1  synchronous, active-high
//   start  in  1  request, sampled only while idle
//   FS     in  5  function select (FS_MULT / FS_MULTU), sampled with start
//   S      in  W  multiplicand, sampled with start
//   T      in  W  multiplier, sampled with start
//   busy   out 1  operation in progress
//   done   out 1  one-cycle pulse, result valid from this cycle
//   Y_hi   out W  upper half of the product
//   Y_lo   out W  lower half of the product
//   N      out 1  Y_hi[W-1]
//   Z      out 1  product is zero

module mpy_seq
    import mpy_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [4:0]   FS,
    input  logic [W-1:0] S,
    input  logic [W-1:0] T,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Y_hi,
    output logic [W-1:0] Y_lo,
    output logic         N,
    output logic         Z
);

    localparam int CW = $clog2(W + 1);

    state_t            state;
    state_t            state_next;

    logic [W-1:0]      mag_s;
    logic [W-1:0]      mag_t;
    logic              neg;
    logic [2*W-1:0]    acc;
    logic [CW-1:0]     cnt;

    logic              accept;
    logic              signed_mode;
    logic              last_step;
    logic [W-1:0]      s_mag;
    logic [W-1:0]      t_mag;
    logic [W:0]        addend;
    logic [W:0]        sum;
    logic [2*W-1:0]    prod;

    assign signed_mode = (FS == FS_MULT);
    assign accept      = (state == IDLE) && start && is_mul_fs(FS);
    assign last_step   = (cnt == CW'(W - 1));

    // Operand magnitudes; only signed mode treats the MSB as a sign
    mpy_abs #(.W(W)) u_abs_s (
        .a   (S),
        .neg (signed_mode & S[W-1]),
        .mag (s_mag)
    );

    mpy_abs #(.W(W)) u_abs_t (
        .a   (T),
        .neg (signed_mode & T[W-1]),
        .mag (t_mag)
    );

    // Final sign correction of the unsigned magnitude product
    mpy_abs #(.W(2 * W)) u_abs_p (
        .a   (acc),
        .neg (neg),
        .mag (prod)
    );

    // One shift-add step: add the multiplicand into the upper half with a
    // carry bit, so the following right shift keeps the full W+1-bit sum.
    always_comb begin
        addend = '0;
        if (mag_t[0]) begin
            addend = {1'b0, mag_s};
        end
        sum = {1'b0, acc[2*W-1:W]} + addend;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: RUN lasts exactly W cycles, FIX exactly one
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (last_step) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, write the
    // result and pulse done when leaving FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            mag_s <= '0;
            mag_t <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            Y_hi  <= '0;
            Y_lo  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag_s <= s_mag;
                        mag_t <= t_mag;
                        neg   <= signed_mode & (S[W-1] ^ T[W-1]);
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= {sum, acc[W-1:1]};
                    mag_t <= mag_t >> 1;
                    cnt   <= cnt + CW'(1);
                end
                FIX: begin
                    Y_hi <= prod[2*W-1:W];
                    Y_lo <= prod[W-1:0];
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Flags follow the held result, so they stay valid between operations
    assign busy = (state != IDLE);
    assign N    = Y_hi[W-1];
    assign Z    = ~|{Y_hi, Y_lo};

endmodule

// File: tb/tb_mpy_seq.sv
// tb_mpy_seq
// Directed testbench for mpy_seq with an 8-bit and a 32-bit instance.
// Expected products are hand-computed constants.

module tb_mpy_seq;
    import mpy_pkg::*;

    logic        clk;
    logic        reset;

    // 8-bit instance
    logic        start8;
    logic [4:0]  fs8;
    logic [7:0]  s8;
    logic [7:0]  t8;
    logic        busy8;
    logic        done8;
    logic [7:0]  yhi8;
    logic [7:0]  ylo8;
    logic        n8;
    logic        z8;

    // 32-bit instance
    logic        start32;
    logic [4:0]  fs32;
    logic [31:0] s32;
    logic [31:0] t32;
    logic        busy32;
    logic        done32;
    logic [31:0] yhi32;
    logic [31:0] ylo32;
    logic        n32;
    logic        z32;

    int compared;
    int mismatched;
    int lat;
    int pulses;

    mpy_seq #(.W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .FS    (fs8),
        .S     (s8),
        .T     (t8),
        .busy  (busy8),
        .done  (done8),
        .Y_hi  (yhi8),
        .Y_lo  (ylo8),
        .N     (n8),
        .Z     (z8)
    );

    mpy_seq #(.W(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .start (start32),
        .FS    (fs32),
        .S     (s32),
        .T     (t32),
        .busy  (busy32),
        .done  (done32),
        .Y_hi  (yhi32),
        .Y_lo  (ylo32),
        .N     (n32),
        .Z     (z32)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it when it does not match
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Presents a request to the 8-bit instance for exactly one edge
    task automatic applyStimulus(input logic [4:0] fs, input logic [7:0] s,
                                 input logic [7:0] t);
        start8 = 1'b1;
        fs8    = fs;
        s8     = s;
        t8     = t;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        fs8    = 5'h00;
        s8     = 8'h00;
        t8     = 8'h00;
    endtask

    // Waits for done8, counting edges since the accept edge; -1 on timeout
    task automatic waitDone8(input int already, output int cycles);
        cycles = -1;
        for (int c = already + 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                cycles = c;
                break;
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        start8     = 1'b0;
        fs8        = 5'h00;
        s8         = 8'h00;
        t8         = 8'h00;
        start32    = 1'b0;
        fs32       = 5'h00;
        s32        = 32'h0;
        t32        = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        // Reset state
        checkOutput("rst_busy", 64'(busy8), 64'd0);
        checkOutput("rst_done", 64'(done8), 64'd0);
        checkOutput("rst_y", 64'({yhi8, ylo8}), 64'h0000);
        checkOutput("rst_n", 64'(n8), 64'd0);
        checkOutput("rst_z", 64'(z8), 64'd1);
        reset = 1'b0;

        // MULTU FF*FF
        applyStimulus(FS_MULTU, 8'hFF, 8'hFF);
        checkOutput("u_busy", 64'(busy8), 64'd1);
        waitDone8(0, lat);
        checkOutput("u_lat", 64'(lat), 64'd9);
        checkOutput("u_busy_done", 64'(busy8), 64'd0);
        checkOutput("u_y", 64'({yhi8, ylo8}), 64'hFE01);
        checkOutput("u_n", 64'(n8), 64'd1);
        checkOutput("u_z", 64'(z8), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("u_done_pulse", 64'(done8), 64'd0);
        checkOutput("u_hold", 64'({yhi8, ylo8}), 64'hFE01);

        // MULT -128 * 127
        applyStimulus(FS_MULT, 8'h80, 8'h7F);
        waitDone8(0, lat);
        checkOutput("s1_lat", 64'(lat), 64'd9);
        checkOutput("s1_y", 64'({yhi8, ylo8}), 64'hC080);
        checkOutput("s1_n", 64'(n8), 64'd1);
        checkOutput("s1_z", 64'(z8), 64'd0);

        // MULT -128 * -128
        applyStimulus(FS_MULT, 8'h80, 8'h80);
        waitDone8(0, lat);
        checkOutput("s2_y", 64'({yhi8, ylo8}), 64'h4000);
        checkOutput("s2_n", 64'(n8), 64'd0);

        // MULT -1 * -1
        applyStimulus(FS_MULT, 8'hFF, 8'hFF);
        waitDone8(0, lat);
        checkOutput("s3_y", 64'({yhi8, ylo8}), 64'h0001);
        checkOutput("s3_n", 64'(n8), 64'd0);

        // MULT 0 * 0x5A
        applyStimulus(FS_MULT, 8'h00, 8'h5A);
        waitDone8(0, lat);
        checkOutput("s4_y", 64'({yhi8, ylo8}), 64'h0000);
        checkOutput("s4_z", 64'(z8), 64'd1);
        checkOutput("s4_n", 64'(n8), 64'd0);

        // 32-bit MULT -2 * 3
        start32 = 1'b1;
        fs32    = FS_MULT;
        s32     = 32'hFFFF_FFFE;
        t32     = 32'd3;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        s32     = 32'h0;
        t32     = 32'h0;
        lat     = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (done32) begin
                lat = c;
                break;
            end
        end
        checkOutput("w32_lat", 64'(lat), 64'd33);
        checkOutput("w32_y", {yhi32, ylo32}, 64'hFFFF_FFFF_FFFF_FFFA);
        checkOutput("w32_n", 64'(n32), 64'd1);

        // Start while busy is ignored: 0x0C * 0x0D = 0x9C
        applyStimulus(FS_MULTU, 8'h0C, 8'h0D);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(FS_MULTU, 8'hFF, 8'hFF);
        checkOutput("ign_busy", 64'(busy8), 64'd1);
        waitDone8(4, lat);
        checkOutput("ign_lat", 64'(lat), 64'd9);
        checkOutput("ign_y", 64'({yhi8, ylo8}), 64'h009C);

        // Start in the done cycle: 3 * 5
        applyStimulus(FS_MULTU, 8'd3, 8'd5);
        checkOutput("b2b_busy", 64'(busy8), 64'd1);
        waitDone8(0, lat);
        checkOutput("b2b_lat", 64'(lat), 64'd9);
        checkOutput("b2b_y", 64'({yhi8, ylo8}), 64'h000F);

        // Illegal function select
        @(posedge clk);
        #1;
        applyStimulus(5'h04, 8'h11, 8'h22);
        checkOutput("ill_busy", 64'(busy8), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("ill_busy2", 64'(busy8), 64'd0);
        checkOutput("ill_hold", 64'({yhi8, ylo8}), 64'h000F);

        // Reset mid-RUN aborts the operation
        applyStimulus(FS_MULTU, 8'h12, 8'h34);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("abort_busy", 64'(busy8), 64'd0);
        checkOutput("abort_y", 64'({yhi8, ylo8}), 64'h0000);
        checkOutput("abort_z", 64'(z8), 64'd1);
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            if (done8) pulses++;
        end
        checkOutput("abort_no_done", 64'(pulses), 64'd0);

        // Normal operation after the abort: 7 * 9
        applyStimulus(FS_MULTU, 8'd7, 8'd9);
        waitDone8(0, lat);
        checkOutput("post_lat", 64'(lat), 64'd9);
        checkOutput("post_y", 64'({yhi8, ylo8}), 64'h003F);
        checkOutput("post_z", 64'(z8), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
